// File: rtl/uart_isp_loader.sv
// UART in-system-programming loader: 8N1 bytes are packed little-endian
// into RAM words and written out while ISPEN holds the CPU in reset.
module uart_isp_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 12,
  parameter int WORDS        = 200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RXD,
  input  logic              ISPEN,
  output logic              WR,
  output logic [ADDR_W-1:0] WRADDR,
  output logic [DATA_W-1:0] WRDATA,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              FERR
);

  localparam int BYTES = DATA_W / 8;
  localparam int CW    = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW    = ($clog2(BYTES) > 0) ? $clog2(BYTES) : 1;
  localparam int AW1   = ADDR_W + 1;
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;

  localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW1-1:0] WORDS_V = AW1'(WORDS);
  localparam logic [31:0]    TO_M1   = 32'(TO_CYC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic              rxd_s1, rxd_s2, rxd_q;
  logic              isp_s1, isp_s2, isp_q;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic [BW-1:0]     byte_idx;
  logic [DATA_W-1:0] word, word_next;
  logic [AW1-1:0]    word_idx;
  logic [31:0]       to_cnt;
  logic              wr_q;
  logic              isp_rise, rxd_fall;

  assign isp_rise = isp_s2 & ~isp_q;
  assign rxd_fall = rxd_q & ~rxd_s2;
  assign WR       = wr_q & isp_s2;
  assign CPU_HOLD = isp_s2 | RESET;

  always_comb begin
    word_next = word;
    for (int k = 0; k < BYTES; k++)
      if (byte_idx == BW'(k)) word_next[8*k +: 8] = shreg;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_q    <= 1'b1;
      isp_s1   <= 1'b0;
      isp_s2   <= 1'b0;
      isp_q    <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_idx <= '0;
      word     <= '0;
      word_idx <= '0;
      to_cnt   <= '0;
      wr_q     <= 1'b0;
      WRADDR   <= '0;
      WRDATA   <= '0;
      DONE     <= 1'b0;
      FERR     <= 1'b0;
    end else begin
      rxd_s1 <= RXD;
      rxd_s2 <= rxd_s1;
      rxd_q  <= rxd_s2;
      isp_s1 <= ISPEN;
      isp_s2 <= isp_s1;
      isp_q  <= isp_s2;
      wr_q   <= 1'b0;
      if (WR && WRADDR == ADDR_W'(WORDS - 1)) DONE <= 1'b1;
      // A low ISPEN aborts everything in flight, including a word completing now
      if (!isp_s2) begin
        state    <= IDLE;
        cnt      <= '0;
        bit_idx  <= '0;
        byte_idx <= '0;
        to_cnt   <= '0;
      end else if (isp_rise) begin
        state    <= IDLE;
        byte_idx <= '0;
        word_idx <= '0;
        to_cnt   <= '0;
        DONE     <= 1'b0;
        FERR     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt     <= '0;
            bit_idx <= '0;
            if (byte_idx == '0) to_cnt <= '0;
            else if (to_cnt == TO_M1) begin
              byte_idx <= '0;
              to_cnt   <= '0;
            end else to_cnt <= to_cnt + 32'd1;
            if (rxd_fall && !DONE && word_idx < WORDS_V) begin
              state  <= START;
              to_cnt <= '0;
            end
          end
          START: begin
            if (cnt == HALF_M1) begin
              cnt   <= '0;
              state <= rxd_s2 ? IDLE : DATA;
            end else cnt <= cnt + CW'(1);
          end
          DATA: begin
            if (cnt == FULL_M1) begin
              cnt     <= '0;
              shreg   <= {rxd_s2, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else cnt <= cnt + CW'(1);
          end
          STOP: begin
            if (cnt == FULL_M1) begin
              cnt   <= '0;
              state <= IDLE;
              if (!rxd_s2) begin
                FERR     <= 1'b1;
                byte_idx <= '0;
              end else if (byte_idx == BW'(BYTES - 1)) begin
                wr_q     <= 1'b1;
                WRADDR   <= word_idx[ADDR_W-1:0];
                WRDATA   <= word_next;
                word_idx <= word_idx + AW1'(1);
                byte_idx <= '0;
              end else begin
                word     <= word_next;
                byte_idx <= byte_idx + BW'(1);
              end
            end else cnt <= cnt + CW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_isp_loader.sv
// Bench for uart_isp_loader: a 32-bit and a 16-bit loader share one UART
// line and are checked against a byte-level model of the download protocol.
module tb_uart_isp_loader;

  localparam int CPB = 16;
  localparam int TOB = 4;

  logic        clk = 1'b0;
  logic        reset, rxd, ispen;
  logic        wr0, hold0, done0, ferr0;
  logic [3:0]  wraddr0;
  logic [31:0] wrdata0;
  logic        wr1, hold1, done1, ferr1;
  logic [2:0]  wraddr1;
  logic [15:0] wrdata1;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr0 = 0;
  int n_wr1 = 0;
  int last_addr0 = -1;

  int          widx[2];
  int          bidx[2];
  logic [31:0] part[2];
  bit          mdone[2];
  bit          mferr[2];
  bit          isp_m;
  int          nb[2] = '{4, 2};
  int          nw[2] = '{8, 4};
  logic [63:0] exq0[$];
  logic [63:0] exq1[$];

  always #5 clk = ~clk;

  uart_isp_loader #(
    .CLKS_PER_BIT(CPB), .DATA_W(32), .ADDR_W(4),
    .WORDS(8), .TIMEOUT_BITS(TOB)
  ) u0 (
    .CLK(clk), .RESET(reset), .RXD(rxd), .ISPEN(ispen),
    .WR(wr0), .WRADDR(wraddr0), .WRDATA(wrdata0),
    .CPU_HOLD(hold0), .DONE(done0), .FERR(ferr0)
  );

  uart_isp_loader #(
    .CLKS_PER_BIT(CPB), .DATA_W(16), .ADDR_W(3),
    .WORDS(4), .TIMEOUT_BITS(TOB)
  ) u1 (
    .CLK(clk), .RESET(reset), .RXD(rxd), .ISPEN(ispen),
    .WR(wr1), .WRADDR(wraddr1), .WRDATA(wrdata1),
    .CPU_HOLD(hold1), .DONE(done1), .FERR(ferr1)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr0) begin
      n_wr0++;
      last_addr0 = int'(wraddr0);
      if (exq0.size() == 0) check("wr0_extra", 1, 0);
      else check("wr0", {32'(wraddr0), wrdata0}, exq0.pop_front());
    end
    if (wr1) begin
      n_wr1++;
      if (exq1.size() == 0) check("wr1_extra", 1, 0);
      else check("wr1", {32'(wraddr1), 16'h0, wrdata1}, exq1.pop_front());
    end
  end

  function automatic void model_clear(int i);
    widx[i] = 0; bidx[i] = 0; part[i] = 0;
    mdone[i] = 0; mferr[i] = 0;
  endfunction

  function automatic void model_byte(int i, logic [7:0] b, bit good);
    if (!isp_m || mdone[i]) return;
    if (!good) begin
      mferr[i] = 1; bidx[i] = 0; part[i] = 0;
      return;
    end
    part[i] = part[i] | (32'(b) << (8 * bidx[i]));
    bidx[i]++;
    if (bidx[i] == nb[i]) begin
      if (i == 0) exq0.push_back({32'(widx[i]), part[i]});
      else exq1.push_back({32'(widx[i]), part[i]});
      widx[i]++; bidx[i] = 0; part[i] = 0;
      if (widx[i] == nw[i]) mdone[i] = 1;
    end
  endfunction

  function automatic void model_abort();
    isp_m = 0;
    for (int i = 0; i < 2; i++) begin bidx[i] = 0; part[i] = 0; end
  endfunction

  task automatic set_isp(bit v);
    @(negedge clk);
    ispen = v;
    if (v) begin
      isp_m = 1;
      model_clear(0);
      model_clear(1);
    end else model_abort();
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b, bit good, int gap, int abort_bit);
    if (abort_bit < 0)
      for (int i = 0; i < 2; i++) model_byte(i, b, good);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k == abort_bit) begin
        ispen = 1'b0;
        model_abort();
      end
      rxd = b[k];
      repeat (CPB) @(negedge clk);
    end
    rxd = good;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_rand(int n);
    for (int j = 0; j < n; j++)
      send_byte(8'($urandom), 1'b1, $urandom_range(10, 2), -1);
  endtask

  task automatic long_idle();
    repeat (TOB * CPB + 40) @(negedge clk);
    for (int i = 0; i < 2; i++)
      if (bidx[i] > 0) begin bidx[i] = 0; part[i] = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wr0", wr0, 0);
    check("rst_addr0", wraddr0, 0);
    check("rst_data0", wrdata0, 0);
    check("rst_done0", done0, 0);
    check("rst_ferr0", ferr0, 0);
    check("rst_hold0", hold0, 1);
    check("rst_done1", done1, 0);
    check("rst_ferr1", ferr1, 0);
    model_clear(0);
    model_clear(1);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int w0;
    reset = 1'b1; rxd = 1'b1; ispen = 1'b0; isp_m = 0;
    model_clear(0);
    model_clear(1);
    repeat (3) @(negedge clk);
    do_reset();
    check("hold_idle", hold0, 0);
    set_isp(1);
    check("hold_on", hold0, 1);

    send_byte(8'h78, 1'b1, 50, -1);
    send_byte(8'h56, 1'b1, 50, -1);
    send_byte(8'h34, 1'b1, 50, -1);
    send_byte(8'h12, 1'b1, 50, -1);
    check("first_cnt0", n_wr0, 1);
    check("first_cnt1", n_wr1, 2);

    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_ferr0", ferr0, 0);
    check("glitch_ferr1", ferr1, 0);
    check("glitch_cnt1", n_wr1, 2);

    send_byte(8'($urandom), 1'b0, 5, -1);
    check("ferr0", ferr0, 1);
    check("ferr1", ferr1, 1);
    check("ferr_cnt0", n_wr0, 1);
    send_rand(4);
    check("done1", done1, mdone[1]);

    send_rand(2);
    long_idle();
    send_rand(4);
    check("timeout_cnt0", n_wr0, 3);

    while (!mdone[0]) send_rand(1);
    repeat (4) @(negedge clk);
    check("done0", done0, 1);
    check("full_cnt0", n_wr0, 8);
    check("last_addr0", last_addr0, 7);
    send_rand(4);
    check("over_cnt0", n_wr0, 8);

    set_isp(0);
    check("fall_hold0", hold0, 0);
    check("fall_hold1", hold1, 0);
    check("fall_done0", done0, 1);
    check("fall_ferr0", ferr0, mferr[0]);
    set_isp(1);
    check("rise_done0", done0, 0);
    check("rise_ferr0", ferr0, 0);
    check("rise_done1", done1, 0);

    send_rand(3);
    w0 = n_wr0;
    send_byte(8'($urandom), 1'b1, 5, 4);
    repeat (4) @(negedge clk);
    check("abort_hold0", hold0, 0);
    check("abort_cnt0", n_wr0, w0);
    set_isp(1);
    send_rand(4);
    check("restart_addr0", last_addr0, 0);

    send_rand(2);
    do_reset();
    send_rand(4);
    check("post_rst_addr0", last_addr0, 0);

    repeat (10) @(negedge clk);
    check("exq0_left", exq0.size(), 0);
    check("exq1_left", exq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_isp_loader.md
UART_ISP_LOADER -- requirements
Module: uart_isp_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, sets the UART bit period in CLK cycles (115200 baud at 50 MHz).
REQ-002 Parameter DATA_W, default 32, sets the RAM word width; it SHALL be a multiple of 8, giving BYTES = DATA_W/8.
REQ-003 Parameter ADDR_W, default 12, sets the RAM word-address width.
REQ-004 Parameter WORDS, default 200, sets the number of words per image; it SHALL be at most 2^ADDR_W.
REQ-005 Parameter TIMEOUT_BITS, default 32, sets the inter-byte timeout in bit periods.
REQ-006 CLK  in  1  single system clock; all logic is on its rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 RXD  in  1  asynchronous UART serial input, idle high, 8N1, LSB first.
REQ-009 ISPEN  in  1  asynchronous download enable; level-sensitive; loader active while high.
REQ-010 WR  out  1  RAM write strobe, one-cycle pulse per word.
REQ-011 WRADDR  out  ADDR_W  RAM word address, valid while WR=1.
REQ-012 WRDATA  out  DATA_W  RAM write data, valid while WR=1.
REQ-013 CPU_HOLD  out  1  holds the CPU in reset while the download is active.
REQ-014 DONE  out  1  sticky flag: WORDS words written.
REQ-015 FERR  out  1  sticky flag: framing error seen.

Function
REQ-016 RXD and ISPEN SHALL each pass through a 2-flop synchronizer before use; all timing below counts from the synchronized signals.
REQ-017 The RX FSM SHALL have states IDLE, START, DATA and STOP, with a bit counter of clog2(CLKS_PER_BIT) bits.
- IDLE -> START on a synchronized RXD falling edge while ISPEN=1 and DONE=0.
REQ-018 In START, RXD SHALL be sampled at CLKS_PER_BIT/2.
- Low: go to DATA.
- High: glitch; return to IDLE with no error.
REQ-019 DATA SHALL take 8 samples spaced CLKS_PER_BIT apart, shifting them in LSB first, then go to STOP.
REQ-020 In STOP, RXD SHALL be sampled one bit period after the last data sample.
- High: byte accepted.
- Low: FERR set, byte discarded, partial word discarded.
- Either way, return to IDLE.
REQ-021 Accepted byte k (0..BYTES-1) of a word SHALL be placed at bits [8k+7:8k] (little-endian).
REQ-022 When byte BYTES-1 is accepted, WR SHALL assert on the next cycle for exactly one cycle, with WRADDR = word index and WRDATA = the assembled word; the word index then increments and the byte index clears.
REQ-023 After the write of word index WORDS-1, DONE SHALL set one cycle after that WR; while DONE=1 further start bits are ignored.
REQ-024 Inter-byte timeout:
- While 0 < byte index < BYTES and the FSM is in IDLE for TIMEOUT_BITS*CLKS_PER_BIT consecutive cycles, the partial word SHALL be discarded.
- The word index is kept and FERR is not set.
REQ-025 On the synchronized ISPEN rising edge, the block SHALL clear the word index, byte index, DONE and FERR.
REQ-026 On the synchronized ISPEN falling edge, the block SHALL abort any byte in progress, discard any partial word and return the FSM to IDLE; DONE and FERR SHALL hold their values.
REQ-027 If ISPEN falls in the same cycle a word completes, the abort SHALL win and no WR is issued.
REQ-028 CPU_HOLD SHALL equal synchronized ISPEN OR RESET.
REQ-029 WR SHALL never assert while ISPEN (synchronized) is 0, and WRADDR SHALL never reach WORDS.

Reset
REQ-030 RESET SHALL force the following, one cycle after RESET is sampled:
- FSM to IDLE; all counters and synchronizers to their idle values (RXD synchronizer to 1).
- Outputs: WR=0, WRADDR=0, WRDATA=0, DONE=0, FERR=0, CPU_HOLD=1.
REQ-031 RESET asserted mid-byte or mid-word SHALL discard all partial data, and no WR SHALL follow.

Verification
REQ-032 Default parameters, ISPEN=1, send bytes 78 56 34 12 at 8680 ns per bit with 1 us gaps -> exactly one WR with WRADDR=0 and WRDATA=0x12345678, issued one cycle after the final stop-bit sample.
REQ-033 Send 200 words with incrementing values -> WR count is 200, the last WRADDR is 199, DONE=1, and a 201st word produces no WR.
REQ-034 Send a byte with the stop bit driven low -> FERR=1 and no WR; the next 4 good bytes write to the same WRADDR as before.
REQ-035 Send 2 bytes, then idle for 32*434+1 cycles, then send 4 bytes -> one WR containing only the last 4 bytes.
REQ-036 Drop ISPEN after the 4th data bit of the last byte of a word -> no WR and CPU_HOLD falls; raising ISPEN again clears the word index to 0 and clears DONE.
REQ-037 A 3000 ns low pulse on RXD -> no byte accepted and FERR=0; a DATA_W=16, WORDS=4 instance writes byte pairs correctly.
